// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU issue path: opcodes, sequencer states,
// instruction field positions and register-file geometry.
package alu_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned REG_N  = 4;
   localparam int unsigned REG_AW = 2;
   localparam int unsigned OC_W   = 3;

   localparam logic [OC_W-1:0] OP_ADD = 3'b000;
   localparam logic [OC_W-1:0] OP_SUB = 3'b001;
   localparam logic [OC_W-1:0] OP_MUL = 3'b010;
   localparam logic [OC_W-1:0] OP_DIV = 3'b011;
   localparam logic [OC_W-1:0] OP_NOT = 3'b100;
   localparam logic [OC_W-1:0] OP_XOR = 3'b101;
   localparam logic [OC_W-1:0] OP_OR  = 3'b110;
   localparam logic [OC_W-1:0] OP_AND = 3'b111;

   localparam int unsigned OC_MSB   = 8;
   localparam int unsigned OC_LSB   = 6;
   localparam int unsigned DST_MSB  = 5;
   localparam int unsigned DST_LSB  = 4;
   localparam int unsigned SRCA_MSB = 3;
   localparam int unsigned SRCA_LSB = 2;
   localparam int unsigned SRCB_MSB = 1;
   localparam int unsigned SRCB_LSB = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB
   } state_t;

endpackage

// File: rtl/regfile_4x4.sv
// 4x4-bit register file: two registered operand read ports, a combinational
// debug port, and writeback/load write ports with writeback priority.
module regfile_4x4
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [REG_AW-1:0] rd_addr_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ld_en,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [REG_N];

   assign dbg_data = regs[dbg_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         // Writeback is assigned last so it wins an address collision with a load.
         if (ld_en) regs[ld_addr] <= ld_data;
         if (wb_en) regs[wb_addr] <= wb_data;
         if (rd_en) begin
            rd_data_a <= regs[rd_addr_a];
            rd_data_b <= regs[rd_addr_b];
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issuer for the external 4-bit ALU: accept, read operands,
// execute, write back. One instruction every four cycles.
module alu_sequencer
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [8:0]  instr,
   input  logic        ld_valid,
   input  logic [1:0]  ld_addr,
   input  logic [3:0]  ld_data,
   output logic [2:0]  alu_oc,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   input  logic [3:0]  alu_f,
   output logic        res_valid,
   output logic [3:0]  res_data,
   output logic [1:0]  res_dst,
   output logic        div_zero,
   input  logic [1:0]  dbg_addr,
   output logic [3:0]  dbg_data
);

   state_t            state;
   logic [REG_AW-1:0] dst_q;
   logic [REG_AW-1:0] srca_q;
   logic [REG_AW-1:0] srcb_q;

   // WB state coincides with the res_valid pulse; a zero-divide suppresses the write.
   regfile_4x4 u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (state == S_READ),
      .rd_addr_a (srca_q),
      .rd_addr_b (srcb_q),
      .rd_data_a (alu_a),
      .rd_data_b (alu_b),
      .wb_en     (res_valid && !div_zero),
      .wb_addr   (res_dst),
      .wb_data   (res_data),
      .ld_en     (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         instr_ready <= 1'b1;
         alu_oc      <= OP_ADD;
         dst_q       <= '0;
         srca_q      <= '0;
         srcb_q      <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_dst     <= '0;
         div_zero    <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         div_zero  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  alu_oc      <= instr[OC_MSB:OC_LSB];
                  dst_q       <= instr[DST_MSB:DST_LSB];
                  srca_q      <= instr[SRCA_MSB:SRCA_LSB];
                  srcb_q      <= instr[SRCB_MSB:SRCB_LSB];
                  instr_ready <= 1'b0;
                  state       <= S_READ;
               end
            end
            S_READ: state <= S_EXEC;
            S_EXEC: begin
               res_data  <= alu_f;
               res_dst   <= dst_q;
               res_valid <= 1'b1;
               div_zero  <= (alu_oc == OP_DIV) && (alu_b == '0);
               state     <= S_WB;
            end
            S_WB: begin
               instr_ready <= 1'b1;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [8:0] instr = '0;
   logic       ld_valid = 1'b0;
   logic [1:0] ld_addr = '0;
   logic [3:0] ld_data = '0;
   logic [2:0] alu_oc;
   logic [3:0] alu_a, alu_b, alu_f;
   logic       res_valid;
   logic [3:0] res_data;
   logic [1:0] res_dst;
   logic       div_zero;
   logic [1:0] dbg_addr = '0;
   logic [3:0] dbg_data;

   int tests = 0;
   int fails = 0;
   int accepts = 0;
   logic [6:0] exp_q [$];

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst),
      .div_zero(div_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Reference ALU; a zero divisor yields 4'hF.
   always_comb begin
      alu_f = '0;
      case (alu_oc)
         3'b000: alu_f = alu_a + alu_b;
         3'b001: alu_f = alu_a - alu_b;
         3'b010: alu_f = alu_a * alu_b;
         3'b011: alu_f = (alu_b == 4'd0) ? 4'hF : alu_a / alu_b;
         3'b100: alu_f = ~alu_a;
         3'b101: alu_f = alu_a ^ alu_b;
         3'b110: alu_f = alu_a | alu_b;
         3'b111: alu_f = alu_a & alu_b;
      endcase
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) if (!rst && instr_valid && instr_ready) accepts++;

   always @(negedge clk) begin
      if (!rst && res_valid) begin
         if (exp_q.size() == 0) chk("unexpected_res_valid", 1, 0);
         else chk("result{data,dst,dz}", {res_data, res_dst, div_zero}, exp_q.pop_front());
      end
   end

   task automatic load(input logic [1:0] a, input logic [3:0] d);
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic chkreg(input logic [1:0] a, input logic [3:0] e);
      dbg_addr = a;
      #1;
      chk($sformatf("reg_r%0d", a), dbg_data, e);
   endtask

   // mode 0 plain, 1 hold instr_valid while busy, 2 load 4'hA to la during WB, 3 reset in EXEC
   task automatic issue(input logic [8:0] ins, input logic [3:0] ed, input logic edz,
                        input int mode, input logic [1:0] la);
      int n = 0;
      @(negedge clk);
      while (!instr_ready && n < 20) begin @(negedge clk); n++; end
      if (!instr_ready) chk("ready_timeout", 0, 1);
      instr = ins; instr_valid = 1'b1;
      if (mode != 3) exp_q.push_back({ed, ins[5:4], edz});
      @(negedge clk);
      if (mode != 1) instr_valid = 1'b0;
      chk("busy_read", {instr_ready, res_valid}, 0);
      @(negedge clk);
      chk("busy_exec", {instr_ready, res_valid}, 0);
      if (mode == 3) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("abort_ready", instr_ready, 1);
         chk("abort_res_valid", res_valid, 0);
         return;
      end
      @(negedge clk);
      chk("wb_ready_low", instr_ready, 0);
      chk("wb_pulse", res_valid, 1);
      if (mode == 2) begin ld_valid = 1'b1; ld_addr = la; ld_data = 4'hA; end
      @(negedge clk);
      ld_valid = 1'b0; instr_valid = 1'b0;
      chk("idle_ready", instr_ready, 1);
      chk("pulse_one_cycle", res_valid, 0);
   endtask

   initial begin
      int a0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", instr_ready, 1);
      chk("rst_res", {res_valid, res_data, res_dst, div_zero}, 0);
      chk("rst_alu", {alu_oc, alu_a, alu_b}, 0);
      for (int i = 0; i < 4; i++) chkreg(2'(i), 4'd0);

      load(2'd1, 4'd5); load(2'd2, 4'd3);
      issue(9'b000_00_01_10, 4'd8, 1'b0, 0, 2'd0);
      chkreg(2'd0, 4'd8);

      load(2'd1, 4'd2);
      issue(9'b010_11_01_01, 4'd4, 1'b0, 0, 2'd0);
      issue(9'b001_10_11_01, 4'd2, 1'b0, 0, 2'd0);
      chkreg(2'd3, 4'd4); chkreg(2'd2, 4'd2);

      load(2'd1, 4'd9); load(2'd2, 4'd0); load(2'd3, 4'd7);
      issue(9'b011_11_01_10, 4'hF, 1'b1, 0, 2'd0);
      chkreg(2'd3, 4'd7);
      load(2'd2, 4'd2);
      issue(9'b011_11_01_10, 4'd4, 1'b0, 0, 2'd0);
      chkreg(2'd3, 4'd4);

      load(2'd1, 4'd15); load(2'd2, 4'd1);
      issue(9'b000_00_01_10, 4'd0, 1'b0, 0, 2'd0);
      load(2'd1, 4'd0);
      issue(9'b001_00_01_10, 4'd15, 1'b0, 0, 2'd0);
      load(2'd1, 4'd5); load(2'd2, 4'd3);
      issue(9'b100_00_01_10, 4'hA, 1'b0, 0, 2'd0);
      issue(9'b101_00_01_10, 4'd6, 1'b0, 0, 2'd0);
      issue(9'b110_00_01_10, 4'd7, 1'b0, 0, 2'd0);
      issue(9'b111_00_01_10, 4'd1, 1'b0, 0, 2'd0);
      chkreg(2'd0, 4'd1);

      issue(9'b000_00_01_10, 4'd8, 1'b0, 2, 2'd0);
      chkreg(2'd0, 4'd8);
      load(2'd0, 4'd0);
      issue(9'b000_00_01_10, 4'd8, 1'b0, 2, 2'd2);
      chkreg(2'd0, 4'd8); chkreg(2'd2, 4'hA);

      issue(9'b000_00_01_10, 4'd0, 1'b0, 3, 2'd0);
      for (int i = 0; i < 4; i++) chkreg(2'(i), 4'd0);

      load(2'd1, 4'd1); load(2'd2, 4'd2);
      a0 = accepts;
      issue(9'b000_11_01_10, 4'd3, 1'b0, 1, 2'd0);
      chk("single_accept", accepts - a0, 1);
      chkreg(2'd3, 4'd3);

      repeat (6) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
